// File: rtl/table_fsm.sv
// table_fsm: run-time programmable table-driven one-hot FSM with step enable, dwell counter and illegal-state recovery
module table_fsm #(
  parameter int N_STATES = 4,
  parameter int N_INPUTS = 3,
  parameter int N_RULES = 8,
  parameter int INIT_STATE = 0,
  parameter int DWELL_W = 8,
  localparam int SW = N_STATES > 1 ? $clog2(N_STATES) : 1,
  localparam int IW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1,
  localparam int RW = N_RULES > 1 ? $clog2(N_RULES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] in_vec,
  input  logic                step,
  input  logic                cfg_we,
  input  logic [RW-1:0]       cfg_addr,
  input  logic                cfg_valid,
  input  logic [SW-1:0]       cfg_src,
  input  logic [IW-1:0]       cfg_sel,
  input  logic [SW-1:0]       cfg_dst,
  output logic                cfg_err,
  output logic [N_STATES-1:0] n_state,
  output logic [N_STATES-1:0] p_state,
  output logic [SW-1:0]       state_idx,
  output logic [DWELL_W-1:0]  dwell,
  output logic                trans,
  output logic                absorbing
);
  logic [N_STATES-1:0] p_state_q, p_state_d, init_oh, hit_oh;
  logic [DWELL_W-1:0] dwell_q;
  logic trans_q, cfg_err_q;
  logic valid_q [N_RULES];
  logic [SW-1:0] src_q [N_RULES];
  logic [SW-1:0] dst_q [N_RULES];
  logic [IW-1:0] sel_q [N_RULES];
  logic legal, hit, any_src, chg, bad;
  logic [SW-1:0] idx, win;
  assign init_oh = N_STATES'(1) << INIT_STATE;
  assign legal = (p_state_q != '0) && ((p_state_q & (p_state_q - N_STATES'(1))) == '0);
  // binary encode of the present state; only meaningful when legal
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_STATES; i++)
      if (p_state_q[i]) idx = SW'(i);
  end
  assign state_idx = legal ? idx : '0;
  // scan rules in ascending order so the highest matching index wins
  always_comb begin
    hit = 1'b0;
    any_src = 1'b0;
    win = '0;
    for (int r = 0; r < N_RULES; r++)
      if (valid_q[r] && src_q[r] == state_idx) begin
        any_src = 1'b1;
        if (in_vec[sel_q[r]]) begin
          hit = 1'b1;
          win = dst_q[r];
        end
      end
  end
  assign hit_oh = N_STATES'(1) << win;
  assign n_state = !legal ? init_oh : hit ? hit_oh : p_state_q;
  assign p_state_d = (step || !legal) ? n_state : p_state_q;
  assign chg = p_state_d != p_state_q;
  assign bad = 32'(cfg_src) >= N_STATES || 32'(cfg_dst) >= N_STATES ||
               32'(cfg_sel) >= N_INPUTS || 32'(cfg_addr) >= N_RULES;
  // state, dwell, pulses and rule table; table writes land after this edge's evaluation
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_q <= init_oh;
      dwell_q <= '0;
      trans_q <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int r = 0; r < N_RULES; r++) valid_q[r] <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      trans_q <= chg;
      dwell_q <= chg ? '0 : dwell_q + DWELL_W'(dwell_q != '1);
      cfg_err_q <= cfg_we && bad;
      if (cfg_we && !bad) begin
        valid_q[cfg_addr] <= cfg_valid;
        src_q[cfg_addr] <= cfg_src;
        sel_q[cfg_addr] <= cfg_sel;
        dst_q[cfg_addr] <= cfg_dst;
      end
    end
  end
  assign p_state = p_state_q;
  assign dwell = dwell_q;
  assign trans = trans_q;
  assign cfg_err = cfg_err_q;
  assign absorbing = !any_src;
endmodule

// File: tb/tb_table_fsm.sv
// tb_table_fsm: randomized and directed checks of table_fsm against a rule-list reference model
module tb_table_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4, step4, we4, val4, err4, tr4, ab4;
  logic [2:0] in4, addr4;
  logic [1:0] src4, sel4, dst4, idx4;
  logic [3:0] ns4, ps4;
  logic [7:0] dw4;
  logic rst6, step6, we6, val6, err6, tr6, ab6;
  logic [4:0] in6;
  logic [3:0] addr6;
  logic [2:0] src6, sel6, dst6, idx6;
  logic [5:0] ns6, ps6;
  logic [7:0] dw6;
  int total = 0, bad = 0;
  int m_v[8], m_s[8], m_l[8], m_d[8];
  int m_st, m_dw;
  bit m_tr, m_err;

  table_fsm d4 (.clk(clk), .reset(rst4), .in_vec(in4), .step(step4), .cfg_we(we4), .cfg_addr(addr4),
    .cfg_valid(val4), .cfg_src(src4), .cfg_sel(sel4), .cfg_dst(dst4), .cfg_err(err4), .n_state(ns4),
    .p_state(ps4), .state_idx(idx4), .dwell(dw4), .trans(tr4), .absorbing(ab4));
  table_fsm #(.N_STATES(6), .N_INPUTS(5), .N_RULES(12)) d6 (.clk(clk), .reset(rst6), .in_vec(in6),
    .step(step6), .cfg_we(we6), .cfg_addr(addr6), .cfg_valid(val6), .cfg_src(src6), .cfg_sel(sel6),
    .cfg_dst(dst6), .cfg_err(err6), .n_state(ns6), .p_state(ps6), .state_idx(idx6), .dwell(dw6),
    .trans(tr6), .absorbing(ab6));

  function automatic int m_next();
    for (int r = 7; r >= 0; r--)
      if (m_v[r] != 0 && m_s[r] == m_st && in4[m_l[r]]) return m_d[r];
    return m_st;
  endfunction

  function automatic bit m_abs();
    for (int r = 0; r < 8; r++)
      if (m_v[r] != 0 && m_s[r] == m_st) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [20:0] exp4();
    logic [3:0] p, n;
    p = 4'b0001 << m_st;
    n = 4'b0001 << m_next();
    return {p, 2'(m_st), 8'(m_dw), m_tr, m_err, m_abs(), n};
  endfunction

  function automatic logic [20:0] obs4();
    return {ps4, idx4, dw4, tr4, err4, ab4, ns4};
  endfunction

  task automatic edge4();
    int nx;
    if (rst4) begin
      m_st = 0; m_dw = 0; m_tr = 0; m_err = 0;
      for (int r = 0; r < 8; r++) m_v[r] = 0;
    end else begin
      nx = step4 ? m_next() : m_st;
      m_tr = nx != m_st;
      m_dw = m_tr ? 0 : (m_dw < 255 ? m_dw + 1 : 255);
      m_st = nx;
      m_err = we4 && (int'(src4) >= 4 || int'(dst4) >= 4 || int'(sel4) >= 3);
      if (we4 && !m_err) begin
        m_v[addr4] = val4; m_s[addr4] = src4; m_l[addr4] = sel4; m_d[addr4] = dst4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    edge4();
    rst4 = 1'b0;
  endtask

  task automatic wr4(input int a, input int v, input int s, input int l, input int d);
    we4 = 1'b1; addr4 = 3'(a); val4 = 1'(v); src4 = 2'(s); sel4 = 2'(l); dst4 = 2'(d);
    edge4();
    we4 = 1'b0;
  endtask

  task automatic load4();
    wr4(0, 1, 0, 0, 1);
    wr4(1, 1, 1, 2, 3);
    wr4(2, 1, 1, 1, 2);
    wr4(3, 1, 3, 2, 2);
  endtask

  task automatic wr6(input int a, input int v, input int s, input int l, input int d);
    we6 = 1'b1; addr6 = 4'(a); val6 = 1'(v); src6 = 3'(s); sel6 = 3'(l); dst6 = 3'(d);
    @(posedge clk); #1;
    we6 = 1'b0;
  endtask

  task automatic test_reset();
    in4 = 3'b000; step4 = 1'b1;
    reset4();
    total++;
    if (ps4 !== 4'b0001 || dw4 !== 8'd0 || tr4 !== 1'b0 || err4 !== 1'b0 || ab4 !== 1'b1)
      begin bad++; $display("FAIL reset: got ps=%b dw=%0d tr=%b err=%b ab=%b exp 0001/0/0/0/1", ps4, dw4, tr4, err4, ab4); end
    total++;
    if (obs4() !== exp4()) begin bad++; $display("FAIL reset_model: got %h exp %h", obs4(), exp4()); end
  endtask

  task automatic test_walk();
    reset4(); load4();
    in4 = 3'b001; edge4();
    total++;
    if (ps4 !== 4'b0010 || tr4 !== 1'b1 || dw4 !== 8'd0)
      begin bad++; $display("FAIL walk_a: got ps=%b tr=%b dw=%0d exp 0010/1/0", ps4, tr4, dw4); end
    in4 = 3'b000; edge4();
    total++;
    if (ps4 !== 4'b0010 || tr4 !== 1'b0 || dw4 !== 8'd1)
      begin bad++; $display("FAIL walk_hold: got ps=%b tr=%b dw=%0d exp 0010/0/1", ps4, tr4, dw4); end
    in4 = 3'b100; edge4();
    total++;
    if (ps4 !== 4'b1000) begin bad++; $display("FAIL walk_c1: got %b exp 1000", ps4); end
    edge4();
    total++;
    if (ps4 !== 4'b0100 || ab4 !== 1'b1 || idx4 !== 2'd2)
      begin bad++; $display("FAIL walk_c2: got ps=%b ab=%b idx=%0d exp 0100/1/2", ps4, ab4, idx4); end
    in4 = 3'b111; edge4();
    total++;
    if (obs4() !== exp4() || ps4 !== 4'b0100)
      begin bad++; $display("FAIL walk_absorb: got %h exp %h", obs4(), exp4()); end
  endtask

  task automatic test_priority();
    reset4(); load4();
    in4 = 3'b001; edge4();
    in4 = 3'b110; edge4();
    total++;
    if (ps4 !== 4'b0100) begin bad++; $display("FAIL prio_hi: got %b exp 0100", ps4); end
    reset4(); load4(); wr4(2, 0, 1, 1, 2);
    in4 = 3'b001; edge4();
    in4 = 3'b110; edge4();
    total++;
    if (ps4 !== 4'b1000 || obs4() !== exp4())
      begin bad++; $display("FAIL prio_dis: got ps=%b exp 1000 (%h vs %h)", ps4, obs4(), exp4()); end
  endtask

  task automatic test_step_dwell();
    int trs = 0;
    reset4(); load4();
    step4 = 1'b0; in4 = 3'b001;
    for (int i = 0; i < 300; i++) begin
      edge4();
      trs += int'(tr4);
      total++;
      if (obs4() !== exp4()) begin bad++; $display("FAIL stall_%0d: got %h exp %h", i, obs4(), exp4()); end
    end
    total++;
    if (ps4 !== 4'b0001 || dw4 !== 8'd255 || trs != 0)
      begin bad++; $display("FAIL stall_sat: got ps=%b dw=%0d trans=%0d exp 0001/255/0", ps4, dw4, trs); end
    step4 = 1'b1; edge4();
    total++;
    if (ps4 !== 4'b0010 || dw4 !== 8'd0 || tr4 !== 1'b1)
      begin bad++; $display("FAIL stall_go: got ps=%b dw=%0d tr=%b exp 0010/0/1", ps4, dw4, tr4); end
  endtask

  task automatic test_cfg();
    reset4();
    step4 = 1'b1; in4 = 3'b001;
    wr4(0, 1, 0, 0, 1);
    total++;
    if (ps4 !== 4'b0001 || err4 !== 1'b0)
      begin bad++; $display("FAIL cfg_same_edge: got ps=%b err=%b exp 0001/0", ps4, err4); end
    edge4();
    total++;
    if (ps4 !== 4'b0010) begin bad++; $display("FAIL cfg_next_edge: got %b exp 0010", ps4); end
    wr4(5, 1, 1, 3, 0);
    total++;
    if (err4 !== 1'b1 || obs4() !== exp4())
      begin bad++; $display("FAIL cfg_reject: got err=%b (%h vs %h) exp err=1", err4, obs4(), exp4()); end
    in4 = 3'b111; edge4();
    total++;
    if (err4 !== 1'b0 || ps4 !== 4'b0010 || ab4 !== 1'b1)
      begin bad++; $display("FAIL cfg_unchanged: got err=%b ps=%b ab=%b exp 0/0010/1", err4, ps4, ab4); end
    wr4(0, 0, 0, 0, 1);
    total++;
    if (obs4() !== exp4()) begin bad++; $display("FAIL cfg_disable: got %h exp %h", obs4(), exp4()); end
  endtask

  task automatic test_recovery();
    reset4(); load4();
    in4 = 3'b001; edge4();
    in4 = 3'b000; step4 = 1'b0;
    force d4.p_state_q = 4'b0110;
    #1;
    total++;
    if (ns4 !== 4'b0001 || idx4 !== 2'd0)
      begin bad++; $display("FAIL recov_comb: got ns=%b idx=%0d exp 0001/0", ns4, idx4); end
    release d4.p_state_q;
    #1;
    @(posedge clk); #1;
    total++;
    if (ps4 !== 4'b0001 || tr4 !== 1'b1 || dw4 !== 8'd0)
      begin bad++; $display("FAIL recov_edge: got ps=%b tr=%b dw=%0d exp 0001/1/0", ps4, tr4, dw4); end
    m_st = 0; m_dw = 0; m_tr = 1; m_err = 0;
    edge4();
    total++;
    if (obs4() !== exp4()) begin bad++; $display("FAIL recov_after: got %h exp %h", obs4(), exp4()); end
    step4 = 1'b1;
  endtask

  task automatic test_reset_mid();
    reset4(); load4();
    in4 = 3'b001; edge4();
    in4 = 3'b100; edge4();
    total++;
    if (ps4 !== 4'b1000) begin bad++; $display("FAIL mid_pre: got %b exp 1000", ps4); end
    reset4();
    total++;
    if (ps4 !== 4'b0001 || dw4 !== 8'd0 || ab4 !== 1'b1 || tr4 !== 1'b0)
      begin bad++; $display("FAIL mid_reset: got ps=%b dw=%0d ab=%b tr=%b exp 0001/0/1/0", ps4, dw4, ab4, tr4); end
    in4 = 3'b111; edge4();
    total++;
    if (ps4 !== 4'b0001 || ab4 !== 1'b1)
      begin bad++; $display("FAIL mid_cleared: got ps=%b ab=%b exp 0001/1", ps4, ab4); end
  endtask

  task automatic test_random();
    reset4();
    for (int i = 0; i < 2000; i++) begin
      we4 = ($urandom_range(3) == 0);
      addr4 = 3'($urandom); val4 = ($urandom_range(4) != 0);
      src4 = 2'($urandom); sel4 = 2'($urandom); dst4 = 2'($urandom);
      step4 = ($urandom_range(3) != 0);
      in4 = 3'($urandom);
      edge4();
      total++;
      if (obs4() !== exp4()) begin bad++; $display("FAIL rand_%0d: got %h exp %h", i, obs4(), exp4()); end
    end
    we4 = 1'b0;
  endtask

  task automatic test_ring6();
    logic [5:0] e;
    rst6 = 1'b1; step6 = 1'b1; in6 = 5'd0;
    @(posedge clk); #1;
    rst6 = 1'b0;
    total++;
    if (ps6 !== 6'b000001 || ab6 !== 1'b1 || dw6 !== 8'd0)
      begin bad++; $display("FAIL ring_reset: got ps=%b ab=%b dw=%0d exp 000001/1/0", ps6, ab6, dw6); end
    for (int r = 0; r < 6; r++) wr6(r, 1, r, 4, (r + 1) % 6);
    wr6(0, 1, 0, 4, 6);
    total++;
    if (err6 !== 1'b1) begin bad++; $display("FAIL ring_err_dst: got %b exp 1", err6); end
    wr6(12, 1, 0, 4, 1);
    total++;
    if (err6 !== 1'b1) begin bad++; $display("FAIL ring_err_addr: got %b exp 1", err6); end
    @(posedge clk); #1;
    total++;
    if (err6 !== 1'b0 || ps6 !== 6'b000001 || ab6 !== 1'b0)
      begin bad++; $display("FAIL ring_idle: got err=%b ps=%b ab=%b exp 0/000001/0", err6, ps6, ab6); end
    in6 = 5'b10000;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      e = 6'b000001 << ((k + 1) % 6);
      total++;
      if (ps6 !== e || int'(idx6) != (k + 1) % 6 || tr6 !== 1'b1 || dw6 !== 8'd0)
        begin bad++; $display("FAIL ring_%0d: got ps=%b idx=%0d tr=%b dw=%0d exp %b", k, ps6, idx6, tr6, dw6, e); end
    end
    in6 = 5'b01111;
    @(posedge clk); #1;
    total++;
    if (ps6 !== 6'b000010 || tr6 !== 1'b0 || dw6 !== 8'd1 || ns6 !== 6'b000010)
      begin bad++; $display("FAIL ring_hold: got ps=%b tr=%b dw=%0d ns=%b exp 000010/0/1/000010", ps6, tr6, dw6, ns6); end
  endtask

  initial begin
    rst4 = 1'b1; step4 = 1'b0; we4 = 1'b0; val4 = 1'b0; in4 = '0; addr4 = '0; src4 = '0; sel4 = '0; dst4 = '0;
    rst6 = 1'b1; step6 = 1'b0; we6 = 1'b0; val6 = 1'b0; in6 = '0; addr6 = '0; src6 = '0; sel6 = '0; dst6 = '0;
    @(posedge clk); #1;
    test_reset();
    test_walk();
    test_priority();
    test_step_dwell();
    test_cfg();
    test_recovery();
    test_reset_mid();
    test_random();
    test_ring6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
